// File: rtl/vec_pkg.sv
// Shared types for the vector issue sequencer.
// Op codes, funct6 values, mem FSM states and hazard helpers.
package vec_pkg;

  typedef enum logic [1:0] {
    OP_ARI   = 2'd0,
    OP_LOAD  = 2'd1,
    OP_STORE = 2'd2,
    OP_RSVD  = 2'd3
  } vop_e;

  typedef enum logic [1:0] {
    MEM_IDLE = 2'd0,
    MEM_REQ  = 2'd1,
    MEM_WAIT = 2'd2
  } mem_st_e;

  localparam logic [5:0] FNC6_VADD   = 6'b000000;
  localparam logic [5:0] FNC6_VFMIN  = 6'b000100;
  localparam logic [5:0] FNC6_VFMAX  = 6'b000110;
  localparam logic [5:0] FNC6_VFMUL  = 6'b100100;
  localparam logic [5:0] FNC6_VFMADD = 6'b101000;
  localparam logic [5:0] FNC6_VFMACC = 6'b101100;

  // Fused multiply-add forms use vd as a third source.
  function automatic logic reads_vd(input logic [5:0] fn6);
    return (fn6 == FNC6_VFMADD) || (fn6 == FNC6_VFMACC);
  endfunction

endpackage

// File: rtl/vec_issue_sequencer_if.sv
// Decode, FPU, LSU and VRF-port signals of the issue sequencer.
// master is the sequencer side, slave the surrounding tile.
interface vec_issue_sequencer_if #(
  parameter int XLEN = 32
);
  logic            io_req_valid;
  logic            io_req_ready;
  logic [1:0]      io_req_op;
  logic [5:0]      io_req_fn6;
  logic [4:0]      io_req_vd;
  logic [4:0]      io_req_vs1;
  logic [4:0]      io_req_vs2;
  logic [XLEN-1:0] io_req_addr;

  logic            io_fpu_valid;
  logic [5:0]      io_fpu_fn6;
  logic [4:0]      io_fpu_vd;
  logic [4:0]      io_fpu_vs1;
  logic [4:0]      io_fpu_vs2;

  logic            io_mem_req_valid;
  logic            io_mem_req_ready;
  logic            io_mem_req_store;
  logic [XLEN-1:0] io_mem_req_addr;
  logic [4:0]      io_mem_req_vreg;
  logic            io_mem_resp_valid;
  logic            io_mem_resp_ready;

  logic            io_vrf_wen;
  logic [4:0]      io_vrf_waddr;
  logic            io_vrf_wsel;
  logic            io_misaligned;
  logic            io_busy;

  modport master (
    input  io_req_valid, io_req_op, io_req_fn6,
    input  io_req_vd, io_req_vs1, io_req_vs2,
    input  io_req_addr,
    output io_req_ready,
    output io_fpu_valid, io_fpu_fn6, io_fpu_vd,
    output io_fpu_vs1, io_fpu_vs2,
    output io_mem_req_valid, io_mem_req_store,
    output io_mem_req_addr, io_mem_req_vreg,
    input  io_mem_req_ready,
    input  io_mem_resp_valid,
    output io_mem_resp_ready,
    output io_vrf_wen, io_vrf_waddr, io_vrf_wsel,
    output io_misaligned, io_busy
  );

  modport slave (
    output io_req_valid, io_req_op, io_req_fn6,
    output io_req_vd, io_req_vs1, io_req_vs2,
    output io_req_addr,
    input  io_req_ready,
    input  io_fpu_valid, io_fpu_fn6, io_fpu_vd,
    input  io_fpu_vs1, io_fpu_vs2,
    input  io_mem_req_valid, io_mem_req_store,
    input  io_mem_req_addr, io_mem_req_vreg,
    output io_mem_req_ready,
    output io_mem_resp_valid,
    input  io_mem_resp_ready,
    input  io_vrf_wen, io_vrf_waddr, io_vrf_wsel,
    input  io_misaligned, io_busy
  );

endinterface

// File: rtl/vec_scoreboard.sv
// Per-vreg busy bits with three lookup ports.
// A set and a clear hitting the same bit resolve to set.
module vec_scoreboard
  import vec_pkg::*;
#(
  parameter int NUM_VREGS = 32
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       set_i,
  input  logic [4:0] set_idx_i,
  input  logic       clr_a_i,
  input  logic [4:0] clr_a_idx_i,
  input  logic       clr_b_i,
  input  logic [4:0] clr_b_idx_i,
  input  logic [4:0] vs1_i,
  input  logic [4:0] vs2_i,
  input  logic [4:0] vd_i,
  output logic       vs1_busy_o,
  output logic       vs2_busy_o,
  output logic       vd_busy_o,
  output logic       any_o
);

  logic [NUM_VREGS-1:0] sb_q;
  logic [NUM_VREGS-1:0] sb_d;

  always_comb begin
    sb_d = sb_q;
    if (clr_a_i) sb_d[clr_a_idx_i] = 1'b0;
    if (clr_b_i) sb_d[clr_b_idx_i] = 1'b0;
    if (set_i)   sb_d[set_idx_i]   = 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) sb_q <= '0;
    else         sb_q <= sb_d;
  end

  // Lookups see only registered state: a retirement
  // does not unblock a request in its own cycle.
  assign vs1_busy_o = sb_q[vs1_i];
  assign vs2_busy_o = sb_q[vs2_i];
  assign vd_busy_o  = sb_q[vd_i];
  assign any_o      = |sb_q;

endmodule

// File: rtl/vec_issue_sequencer.sv
// Vector issue sequencer: hazard check, 0-cycle FPU issue,
// LSU request FSM and VRF write-port arbitration.
module vec_issue_sequencer
  import vec_pkg::*;
#(
  parameter int NUM_VREGS   = 32,
  parameter int FPU_LATENCY = 3,
  parameter int XLEN        = 32
) (
  input logic clock,
  input logic reset_n,
  vec_issue_sequencer_if.master bus
);

  vop_e op;
  logic is_ari, is_ld, is_st, is_mem;
  logic vs1_bsy, vs2_bsy, vd_bsy, sb_any;
  logic rd_haz, wr_haz, haz;
  logic mem_free, ready, accept, aligned;
  logic fpu_go, mem_go, ld_go, mis_go;
  logic rsp_hs, ld_done;
  logic fx_v;
  logic [4:0] fx_vd;

  logic [FPU_LATENCY-1:0] dv_q;
  logic [4:0] dvd_q [FPU_LATENCY];

  mem_st_e st_q, st_d;
  logic            store_q, store_d;
  logic [XLEN-1:0] maddr_q, maddr_d;
  logic [4:0]      mvreg_q, mvreg_d;
  logic            req_v, rsp_rdy;
  logic            mis_q;

  logic       wen, wsel;
  logic [4:0] waddr;

  assign op     = vop_e'(bus.io_req_op);
  assign is_ari = (op == OP_ARI);
  assign is_ld  = (op == OP_LOAD);
  assign is_st  = (op == OP_STORE);
  assign is_mem = is_ld | is_st;

  vec_scoreboard #(
    .NUM_VREGS (NUM_VREGS)
  ) u_sb (
    .clk_i       (clock),
    .rst_ni      (reset_n),
    .set_i       (fpu_go | ld_go),
    .set_idx_i   (bus.io_req_vd),
    .clr_a_i     (fx_v),
    .clr_a_idx_i (fx_vd),
    .clr_b_i     (ld_done),
    .clr_b_idx_i (mvreg_q),
    .vs1_i       (bus.io_req_vs1),
    .vs2_i       (bus.io_req_vs2),
    .vd_i        (bus.io_req_vd),
    .vs1_busy_o  (vs1_bsy),
    .vs2_busy_o  (vs2_bsy),
    .vd_busy_o   (vd_bsy),
    .any_o       (sb_any)
  );

  always_comb begin
    rd_haz = 1'b0;
    wr_haz = 1'b0;
    unique case (1'b1)
      is_ari: begin
        rd_haz = vs1_bsy | vs2_bsy
               | (reads_vd(bus.io_req_fn6) & vd_bsy);
        wr_haz = vd_bsy;
      end
      is_ld:   wr_haz = vd_bsy;
      is_st:   rd_haz = vd_bsy;
      default: ;
    endcase
  end

  assign haz = rd_haz | wr_haz;

  assign fx_v  = dv_q[FPU_LATENCY-1];
  assign fx_vd = dvd_q[FPU_LATENCY-1];

  // FPU writeback owns the port; a load return yields to it.
  assign rsp_hs  = (st_q == MEM_WAIT) & bus.io_mem_resp_valid & ~fx_v;
  assign ld_done = rsp_hs & ~store_q;

  assign mem_free = (st_q == MEM_IDLE) | rsp_hs;
  assign ready    = reset_n & ~haz & (~is_mem | mem_free);
  assign accept   = bus.io_req_valid & ready;
  assign aligned  = (bus.io_req_addr[1:0] == 2'b00);

  assign fpu_go = accept & is_ari;
  assign mem_go = accept & is_mem & aligned;
  assign mis_go = accept & is_mem & ~aligned;
  assign ld_go  = mem_go & is_ld;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      dv_q <= '0;
      for (int i = 0; i < FPU_LATENCY; i++)
        dvd_q[i] <= '0;
    end else begin
      dv_q[0]  <= fpu_go;
      dvd_q[0] <= bus.io_req_vd;
      for (int i = 1; i < FPU_LATENCY; i++) begin
        dv_q[i]  <= dv_q[i-1];
        dvd_q[i] <= dvd_q[i-1];
      end
    end
  end

  always_comb begin
    st_d    = st_q;
    store_d = store_q;
    maddr_d = maddr_q;
    mvreg_d = mvreg_q;
    req_v   = 1'b0;
    rsp_rdy = 1'b0;
    unique case (st_q)
      MEM_IDLE: ;
      MEM_REQ: begin
        req_v = 1'b1;
        if (bus.io_mem_req_ready) st_d = MEM_WAIT;
      end
      MEM_WAIT: begin
        rsp_rdy = ~fx_v;
        if (rsp_hs) st_d = MEM_IDLE;
      end
      default: st_d = MEM_IDLE;
    endcase
    if (mem_go) begin
      st_d    = MEM_REQ;
      store_d = is_st;
      maddr_d = bus.io_req_addr >> 2;
      mvreg_d = bus.io_req_vd;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      st_q    <= MEM_IDLE;
      store_q <= 1'b0;
      maddr_q <= '0;
      mvreg_q <= '0;
      mis_q   <= 1'b0;
    end else begin
      st_q    <= st_d;
      store_q <= store_d;
      maddr_q <= maddr_d;
      mvreg_q <= mvreg_d;
      mis_q   <= mis_go;
    end
  end

  always_comb begin
    wen   = 1'b0;
    wsel  = 1'b0;
    waddr = '0;
    unique case (1'b1)
      fx_v: begin
        wen   = 1'b1;
        waddr = fx_vd;
      end
      ld_done: begin
        wen   = 1'b1;
        wsel  = 1'b1;
        waddr = mvreg_q;
      end
      default: ;
    endcase
  end

  assign bus.io_req_ready = ready;

  assign bus.io_fpu_valid = fpu_go;
  assign bus.io_fpu_fn6   = fpu_go ? bus.io_req_fn6 : '0;
  assign bus.io_fpu_vd    = fpu_go ? bus.io_req_vd  : '0;
  assign bus.io_fpu_vs1   = fpu_go ? bus.io_req_vs1 : '0;
  assign bus.io_fpu_vs2   = fpu_go ? bus.io_req_vs2 : '0;

  assign bus.io_mem_req_valid  = req_v;
  assign bus.io_mem_req_store  = req_v & store_q;
  assign bus.io_mem_req_addr   = req_v ? maddr_q : '0;
  assign bus.io_mem_req_vreg   = req_v ? mvreg_q : '0;
  assign bus.io_mem_resp_ready = rsp_rdy;

  assign bus.io_vrf_wen    = wen;
  assign bus.io_vrf_waddr  = waddr;
  assign bus.io_vrf_wsel   = wsel;
  assign bus.io_misaligned = mis_q;

  assign bus.io_busy = sb_any | (|dv_q) | (st_q != MEM_IDLE);

endmodule

// File: doc/vec_issue_sequencer.md
Name: vec_issue_sequencer

Overview:
- Sits between the scalar core's decode stage and the vector datapath in Tile.
- Accepts decoded vector instructions (VADD/VFMIN/VFMAX/VFMUL/VFMADD/VFMACC, unit-stride VLE32/VSE32).
- Tracks a per-vreg busy scoreboard, issues arithmetic ops to the fixed-latency vector FPU and memory ops to the vector LSU/DTIM port.
- Arbitrates the single VRF write port between FPU writeback and load return.

Parameters:
- NUM_VREGS, 32, number of vector registers tracked.
- FPU_LATENCY, 3, cycles from FPU issue to result-valid; range 1..8.
- XLEN, 32, scalar address width.

Ports:
- clock, input, 1, sole clock.
- reset_n, input, 1, asynchronous active-low reset.
- io_req_valid, input, 1, decoded vector instruction valid.
- io_req_ready, output, 1, sequencer accepts the instruction this cycle.
- io_req_op, input, 2, 0=ARI, 1=LOAD, 2=STORE, 3=reserved.
- io_req_fn6, input, 6, funct6 for ARI.
- io_req_vd, input, 5, destination (store data source for STORE).
- io_req_vs1, input, 5, source 1.
- io_req_vs2, input, 5, source 2.
- io_req_addr, input, XLEN, rs1 value (base address for LOAD/STORE).
- io_fpu_valid, output, 1, FPU issue strobe.
- io_fpu_fn6, output, 6, issued funct6.
- io_fpu_vd, output, 5, issued destination.
- io_fpu_vs1, output, 5, issued source 1.
- io_fpu_vs2, output, 5, issued source 2.
- io_mem_req_valid, output, 1, LSU request valid.
- io_mem_req_ready, input, 1, LSU accepts the request.
- io_mem_req_store, output, 1, 1=store, 0=load.
- io_mem_req_addr, output, XLEN, word address (io_req_addr >> 2).
- io_mem_req_vreg, output, 5, load destination / store source.
- io_mem_resp_valid, input, 1, load data ready / store done.
- io_mem_resp_ready, output, 1, sequencer accepts the response.
- io_vrf_wen, output, 1, VRF write enable.
- io_vrf_waddr, output, 5, VRF write index.
- io_vrf_wsel, output, 1, 0=FPU result, 1=load data.
- io_misaligned, output, 1, one-cycle pulse on a dropped misaligned memory op.
- io_busy, output, 1, any op in flight or any scoreboard bit set.

Behaviour:
- Reset: scoreboard all clear; FPU delay line empty; mem FSM IDLE; all outputs 0 (io_req_ready 0 while reset_n low).
- Reset mid-operation discards all in-flight state with no writebacks.
- Hazard check is combinational on request fields. Registers read per op:
  - ARI reads vs1, vs2, plus vd for fn6 VFMADD/VFMACC.
  - STORE reads vd.
  - ARI and LOAD write vd.
- Stall (io_req_ready=0) when any register read or written is busy, or when a memory op arrives with the mem FSM not IDLE.
- io_req_ready does not depend on io_req_valid.
- A scoreboard bit set and clear in the same cycle resolves to set (new op wins); a clear by retirement does not unblock the same cycle.
- ARI accept: io_fpu_* driven that same cycle (0-cycle issue); scoreboard[vd] set.
  - Tag enters a FPU_LATENCY-deep shift register; on exit: io_vrf_wen=1, wsel=0, waddr=vd, and scoreboard[vd] cleared the following edge.
  - Back-to-back ARI issue at one per cycle is allowed.
- Mem FSM states: IDLE, REQ, WAIT.
  - IDLE + accepted LOAD/STORE with addr[1:0]==0: latch op/addr/vreg, go to REQ; LOAD sets scoreboard[vd], STORE sets nothing (source protected by ready=0 on WAW of its vd).
  - Misaligned (addr[1:0]!=0): accept, pulse io_misaligned next cycle, stay IDLE, no side effects.
  - REQ: io_mem_req_valid=1; on ready go to WAIT.
  - WAIT: io_mem_resp_ready = !(FPU delay-line exit this cycle). On resp handshake:
    - LOAD: io_vrf_wen=1, wsel=1, waddr=vreg, clear scoreboard[vreg].
    - Go to IDLE; a new memory request may be accepted that same cycle.
- Write-port arbitration: FPU has fixed priority and never stalls; load return waits.
- STORE ignores the write port.
- io_busy = |scoreboard | delay-line occupancy | (FSM != IDLE).

Decomposition:
- Shared package vec_pkg holds:
  - op enum (ARI/LOAD/STORE)
  - FNC6_* constants
  - mem FSM state enum
  - function reads_vd(fn6)
- Sub-module vec_scoreboard (set/clear/3 read ports + vd check, set-wins rule).
- Delay line and FSM stay in the top.

Test Plan:
1. VADD vd=3, vs1=1, vs2=2 at cycle 0 -> io_fpu_valid cycle 0; io_vrf_wen/waddr=3 at cycle 3; io_busy low at cycle 4.
2. VFMUL vd=4, then VFMACC vd=5, vs1=4 next cycle -> ready=0 until scoreboard[4] clears; VFMACC issues exactly the cycle after vd=4 writeback.
3. LOAD vd=2, addr=0x0800_0100 with mem_req_ready held low 2 cycles -> req_addr=0x0200_0040; resp writes vrf 2 with wsel=1; scoreboard[2] cleared.
4. LOAD resp_valid in the same cycle as a FPU writeback of vd=7 -> resp_ready=0 that cycle; FPU writes 7 first; load writes the next cycle.
5. STORE vd=2, addr=0x0800_0102 -> io_misaligned pulse; no mem_req_valid; FSM stays IDLE.
6. reset_n low while in WAIT with 2 ARI ops in flight -> all outputs 0 asynchronously; no writebacks after release; io_busy=0.
